// File: rtl/wvb_hdr_rd_arbiter.sv
// Oldest-event header arbiter: scans N_CHAN header FIFOs, pops the smallest evt_ltc
// and hands it to the shared readout engine. Define WVB_ARB_WATCHDOG_EN to add the readout watchdog.
module wvb_hdr_rd_arbiter #(
  parameter int N_CHAN      = 24,
  parameter int HDR_W       = 79,
  parameter int LTC_W       = 49,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CHAN-1:0]       hdr_valid,
  input  logic [N_CHAN*HDR_W-1:0] hdr_bundle,
  output logic [N_CHAN-1:0]       hdr_rdreq,
  output logic                    rdout_req,
  input  logic                    rdout_ack,
  input  logic                    rdout_done,
  output logic [4:0]              rdout_chan,
  output logic [HDR_W-1:0]        rdout_hdr,
  output logic                    busy,
  output logic                    rdout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_GRANT, S_WAIT_ACK, S_WAIT_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_CHAN - 1);

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic               best_vld_q, best_vld_d;
  logic [4:0]         best_idx_q, best_idx_d;
  logic [LTC_W-1:0]   best_ltc_q, best_ltc_d;
  logic [N_CHAN-1:0]  hdr_rdreq_q, hdr_rdreq_d;
  logic               rdout_req_q, rdout_req_d;
  logic [4:0]         rdout_chan_q, rdout_chan_d;
  logic [HDR_W-1:0]   rdout_hdr_q, rdout_hdr_d;

  logic               cur_vld;
  logic [LTC_W-1:0]   cur_ltc;
  logic               sel_vld;
  logic [HDR_W-1:0]   sel_hdr;
  logic               scan_hit;
  logic               wdog_expired;

  // Channel muxes: the one under scan, and the current best candidate.
  always_comb begin
    cur_vld = 1'b0;
    cur_ltc = '0;
    sel_vld = 1'b0;
    sel_hdr = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (idx_q == 5'(c)) begin
        cur_vld = hdr_valid[c];
        cur_ltc = hdr_bundle[c*HDR_W +: LTC_W];
      end
      if (best_idx_q == 5'(c)) begin
        sel_vld = hdr_valid[c];
        sel_hdr = hdr_bundle[c*HDR_W +: HDR_W];
      end
    end
  end

  // Strict compare keeps the lower index on equal timestamps.
  assign scan_hit = cur_vld && (!best_vld_q || (cur_ltc < best_ltc_q));

`ifdef WVB_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        rdout_err_q, rdout_err_d;

  assign wdog_expired = ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE)) &&
                        (wdog_cnt_q == WDOG_LAST);

  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    rdout_err_d = wdog_expired;
    if (state_q == S_GRANT)
      wdog_cnt_d = '0;
    else if ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE))
      wdog_cnt_d = wdog_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q  <= '0;
      rdout_err_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      rdout_err_q <= rdout_err_d;
    end
  end

  assign rdout_err = rdout_err_q;
`else
  // No watchdog: the arbiter waits on the engine forever and the error output stays low.
  assign wdog_expired = 1'b0;
  assign rdout_err    = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (en && (|hdr_valid)) state_d = S_SCAN;
      S_SCAN:      if (idx_q == LAST_IDX)
                     state_d = (best_vld_q || scan_hit) ? S_GRANT : S_IDLE;
      S_GRANT:     state_d = sel_vld ? S_WAIT_ACK : S_IDLE;
      S_WAIT_ACK:  if (rdout_ack) state_d = rdout_done ? S_IDLE : S_WAIT_DONE;
      S_WAIT_DONE: if (rdout_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (wdog_expired) state_d = S_IDLE;
  end

  always_comb begin
    idx_d        = idx_q;
    best_vld_d   = best_vld_q;
    best_idx_d   = best_idx_q;
    best_ltc_d   = best_ltc_q;
    hdr_rdreq_d  = '0;
    rdout_chan_d = rdout_chan_q;
    rdout_hdr_d  = rdout_hdr_q;
    rdout_req_d  = (state_d == S_WAIT_ACK);
    case (state_q)
      S_IDLE: begin
        idx_d      = '0;
        best_vld_d = 1'b0;
      end
      S_SCAN: begin
        idx_d = idx_q + 5'd1;
        if (scan_hit) begin
          best_vld_d = 1'b1;
          best_idx_d = idx_q;
          best_ltc_d = cur_ltc;
        end
      end
      S_GRANT: begin
        if (sel_vld) begin
          rdout_hdr_d  = sel_hdr;
          rdout_chan_d = best_idx_q;
          for (int c = 0; c < N_CHAN; c++)
            hdr_rdreq_d[c] = (best_idx_q == 5'(c));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_vld_q   <= 1'b0;
      hdr_rdreq_q  <= '0;
      rdout_req_q  <= 1'b0;
      rdout_chan_q <= '0;
      rdout_hdr_q  <= '0;
    end else begin
      idx_q        <= idx_d;
      best_vld_q   <= best_vld_d;
      hdr_rdreq_q  <= hdr_rdreq_d;
      rdout_req_q  <= rdout_req_d;
      rdout_chan_q <= rdout_chan_d;
      rdout_hdr_q  <= rdout_hdr_d;
    end
  end

  // Candidate bookkeeping is qualified by best_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    best_idx_q <= best_idx_d;
    best_ltc_q <= best_ltc_d;
  end

  assign hdr_rdreq  = hdr_rdreq_q;
  assign rdout_req  = rdout_req_q;
  assign rdout_chan = rdout_chan_q;
  assign rdout_hdr  = rdout_hdr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_wvb_hdr_rd_arbiter.sv
// Self-checking bench for wvb_hdr_rd_arbiter: vector table, corner sequences and
// randomized transactions against an oldest-timestamp reference model.
module tb_wvb_hdr_rd_arbiter;
  localparam int N   = 4;
  localparam int HW  = 79;
  localparam int LW  = 49;
  localparam int TMO = 10;

  logic              clk = 1'b0;
  logic              rst_n, en, rdout_ack, rdout_done;
  logic [N-1:0]      hdr_valid, hdr_rdreq;
  logic [N*HW-1:0]   hdr_bundle;
  logic              rdout_req, busy, rdout_err;
  logic [4:0]        rdout_chan;
  logic [HW-1:0]     rdout_hdr;
  logic [HW-1:0]     bun [N];

  int checks = 0, failures = 0, pop_cnt = 0, multi_pop = 0;

  typedef struct {
    logic [N-1:0]         vld;
    logic [N-1:0][LW-1:0] ltc;
    int                   exp_chan;
    int                   ack_dly;
    bit                   same_cyc;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign hdr_bundle[g*HW +: HW] = bun[g];
  end

  wvb_hdr_rd_arbiter #(.N_CHAN(N), .HDR_W(HW), .LTC_W(LW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hdr_valid(hdr_valid), .hdr_bundle(hdr_bundle),
    .hdr_rdreq(hdr_rdreq), .rdout_req(rdout_req), .rdout_ack(rdout_ack),
    .rdout_done(rdout_done), .rdout_chan(rdout_chan), .rdout_hdr(rdout_hdr),
    .busy(busy), .rdout_err(rdout_err)
  );

  always @(negedge clk) if (rst_n) begin
    if (hdr_rdreq != '0) pop_cnt++;
    if ($countones(hdr_rdreq) > 1) multi_pop++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] vld, input logic [N-1:0][LW-1:0] ltc);
    for (int c = 0; c < N; c++) bun[c] = {30'($urandom), ltc[c]};
    hdr_valid = vld;
  endtask

  // Oldest event = smallest {ltc, index} key among valid channels.
  function automatic int oldest(input logic [N-1:0] vld, input logic [N-1:0][LW-1:0] ltc);
    logic [LW+1:0] key, best_key;
    int win;
    win = -1;
    best_key = '1;
    for (int c = 0; c < N; c++) begin
      key = {ltc[c], 2'(c)};
      if (vld[c] && (win < 0 || key < best_key)) begin
        best_key = key;
        win = c;
      end
    end
    return win;
  endfunction

  // Called with the DUT idle and inputs already applied for the coming IDLE cycle.
  task automatic do_txn(input int exp_chan, input int ack_dly, input int done_dly,
                        input bit same_cyc, input bit drop_en, input string tag);
    logic [HW-1:0] exp_hdr;
    logic [N-1:0]  oh;
    int            p0;
    exp_hdr = bun[exp_chan];
    oh = '0;
    oh[exp_chan] = 1'b1;
    p0 = pop_cnt;
    repeat (N + 1) tick;
    check({tag, "_early_pop"}, hdr_rdreq, 0);
    check({tag, "_busy_scan"}, busy, 1);
    tick;
    check({tag, "_rdreq"}, hdr_rdreq, oh);
    check({tag, "_req"}, rdout_req, 1);
    check({tag, "_chan"}, rdout_chan, exp_chan);
    check({tag, "_hdr"}, rdout_hdr, exp_hdr);
    for (int i = 0; i < ack_dly; i++) begin
      tick;
      check({tag, "_req_hold"}, rdout_req, 1);
      check({tag, "_rdreq_1clk"}, hdr_rdreq, 0);
      check({tag, "_hdr_hold"}, rdout_hdr, exp_hdr);
    end
    rdout_ack = 1'b1;
    rdout_done = same_cyc;
    tick;
    rdout_ack = 1'b0;
    rdout_done = 1'b0;
    check({tag, "_req_drop"}, rdout_req, 0);
    if (same_cyc) begin
      check({tag, "_idle_same"}, busy, 0);
    end else begin
      check({tag, "_wait_done"}, busy, 1);
      if (drop_en) en = 1'b0;
      repeat (done_dly) tick;
      check({tag, "_still_busy"}, busy, 1);
      rdout_done = 1'b1;
      tick;
      rdout_done = 1'b0;
      check({tag, "_idle"}, busy, 0);
    end
    check({tag, "_chan_after"}, rdout_chan, exp_chan);
    check({tag, "_hdr_after"}, rdout_hdr, exp_hdr);
    check({tag, "_pops"}, pop_cnt - p0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0][LW-1:0] l;
    logic [N-1:0]         v;
    int                   p0;

    rst_n = 1'b0; en = 1'b0; rdout_ack = 1'b0; rdout_done = 1'b0; hdr_valid = '0;
    for (int c = 0; c < N; c++) bun[c] = '0;

    tbl[0] = '{4'b1010, {49'h80, 49'h0, 49'h100, 49'h0}, 3, 1, 1'b0};
    tbl[1] = '{4'b0010, {49'h80, 49'h0, 49'h100, 49'h0}, 1, 0, 1'b0};
    tbl[2] = '{4'b0101, {49'h0, 49'h55, 49'h0, 49'h55}, 0, 2, 1'b0};
    tbl[3] = '{4'b0101, {49'h0, 49'h55, 49'h0, 49'h90}, 2, 0, 1'b1};
    tbl[4] = '{4'b1111, {49'h1_FFFF_FFFF_FFFE, 49'h0_FFFF_FFFF_FFFF,
                         49'h1_0000_0000_0000, 49'h1_FFFF_FFFF_FFFF}, 2, 1, 1'b0};
    tbl[5] = '{4'b1000, {49'h1_FFFF_FFFF_FFFF, 49'h0, 49'h0, 49'h0}, 3, 0, 1'b0};
    tbl[6] = '{4'b1111, {49'h0, 49'h0, 49'h0, 49'h0}, 0, 3, 1'b1};
    tbl[7] = '{4'b1110, {49'h4, 49'h4, 49'h5, 49'h0}, 2, 0, 1'b0};

    #12;
    check("rst_rdreq", hdr_rdreq, 0);
    check("rst_req", rdout_req, 0);
    check("rst_chan", rdout_chan, 0);
    check("rst_hdr", rdout_hdr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", rdout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      load(tbl[i].vld, tbl[i].ltc);
      en = 1'b1;
      do_txn(tbl[i].exp_chan, tbl[i].ack_dly, 1, tbl[i].same_cyc, 1'b0, $sformatf("tbl%0d", i));
    end

    // Sole candidate vanishes in the last scan cycle: no pop, no request.
    load(4'b0100, {49'h0, 49'h7, 49'h0, 49'h0});
    p0 = pop_cnt;
    repeat (4) tick;
    hdr_valid[2] = 1'b0;
    tick;
    check("drop_grant_busy", busy, 1);
    tick;
    check("drop_idle_busy", busy, 0);
    check("drop_idle_req", rdout_req, 0);
    repeat (3) tick;
    check("drop_pops", pop_cnt - p0, 0);

    // Disabled arbiter ignores valid headers and stray done pulses.
    en = 1'b0;
    load(4'b1111, {49'h3, 49'h2, 49'h1, 49'h9});
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("en0_busy", busy, 0);
    end
    rdout_done = 1'b1;
    tick;
    rdout_done = 1'b0;
    check("stray_done_busy", busy, 0);
    check("en0_pops", pop_cnt - p0, 0);

    // en dropped in WAIT_DONE: transaction completes, then stays idle.
    en = 1'b1;
    do_txn(1, 0, 2, 1'b0, 1'b1, "dropen");
    p0 = pop_cnt;
    repeat (6) tick;
    check("dropen_hold_busy", busy, 0);
    check("dropen_hold_pops", pop_cnt - p0, 0);

    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      v = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++)
        l[c] = ($urandom_range(0, 1) == 1) ? 49'($urandom_range(0, 3))
                                            : {17'($urandom), 32'($urandom)};
      load(v, l);
      do_txn(oldest(v, l), $urandom_range(0, 3), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while waiting for the engine's ack.
    load(4'b0001, {49'h0, 49'h0, 49'h0, 49'h12});
    en = 1'b1;
    repeat (N + 2) tick;
    check("arst_pre_req", rdout_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", rdout_req, 0);
    check("arst_busy", busy, 0);
    check("arst_rdreq", hdr_rdreq, 0);
    check("arst_chan", rdout_chan, 0);
    check("arst_hdr", rdout_hdr, 0);
    en = 1'b0;
    hdr_valid = '0;
    #2 rst_n = 1'b1;
    tick;
    check("arst_after_busy", busy, 0);

    // Engine never finishes.
    load(4'b0010, {49'h0, 49'h0, 49'h44, 49'h0});
    en = 1'b1;
    repeat (N + 2) tick;
    check("wd_req_up", rdout_req, 1);
    en = 1'b0;
`ifdef WVB_ARB_WATCHDOG_EN
    for (int i = 0; i < TMO - 1; i++) begin
      tick;
      check("wd_err_early", rdout_err, 0);
      check("wd_req_hold", rdout_req, 1);
    end
    tick;
    check("wd_err_pulse", rdout_err, 1);
    check("wd_req_drop", rdout_req, 0);
    check("wd_busy_idle", busy, 0);
    tick;
    check("wd_err_once", rdout_err, 0);
    check("wd_stay_idle", busy, 0);
`else
    for (int i = 0; i < 2 * TMO; i++) begin
      tick;
      check("nowd_err", rdout_err, 0);
    end
    check("nowd_req_hold", rdout_req, 1);
    check("nowd_busy", busy, 1);
    rdout_ack = 1'b1;
    rdout_done = 1'b1;
    tick;
    rdout_ack = 1'b0;
    rdout_done = 1'b0;
    check("nowd_idle", busy, 0);
`endif

    check("single_pop_bit", multi_pop, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wvb_hdr_rd_arbiter.md
Name: wvb_hdr_rd_arbiter

Overview:
- Schedules readout of waveform-buffer (WVB) headers across N_CHAN ADC channels.
- Each channel presents its next header bundle from its header FIFO: 79 bits, evt_ltc[48:0], start_addr[59:49], stop_addr[70:60], trig_src[72:71], cnst_run[73], pre_conf[78:74].
- The arbiter scans the channels and picks the oldest event (smallest evt_ltc). It pops that header and hands it to the single shared readout engine, then holds off until the engine reports completion.
- Sits between the per-channel WVB header FIFOs and the readout/DAQ engine.

Parameters:
- N_CHAN, 24, number of channels (1..32)
- HDR_W, 79, header bundle width
- LTC_W, 49, evt_ltc width (bundle bits [LTC_W-1:0])
- TIMEOUT_CYC, 65535, readout watchdog limit in clocks (only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable
- hdr_valid  in  N_CHAN  channel header FIFO non-empty
- hdr_bundle  in  N_CHAN*HDR_W  channel c header at [c*HDR_W +: HDR_W]
- hdr_rdreq  out  N_CHAN  one-cycle pop strobe to channel FIFO
- rdout_req  out  1  header presented to readout engine
- rdout_ack  in  1  engine accepted header
- rdout_done  in  1  engine finished waveform readout (1-cycle pulse)
- rdout_chan  out  5  selected channel index
- rdout_hdr  out  HDR_W  latched header of selected channel
- busy  out  1  state != IDLE
- rdout_err  out  1  watchdog abort pulse (optional feature, else tied 0)

Behaviour:
- Reset: clock-independent. All outputs 0; state IDLE; scan index 0; best-valid flag 0.
- FSM states: IDLE, SCAN, GRANT, WAIT_ACK, WAIT_DONE.
- IDLE: if en && |hdr_valid, go to SCAN with idx=0 and best_vld=0.
- SCAN: one channel per clock, idx 0..N_CHAN-1.
  - If hdr_valid[idx] && (!best_vld || ltc[idx] < best_ltc), update best_idx, best_ltc and best_vld.
  - Compare is strict unsigned over LTC_W bits. Ties go to the lowest index. No wrap handling; the 49-bit LTC does not wrap in operation.
  - After idx=N_CHAN-1, go to GRANT if best_vld, else go to IDLE.
- GRANT: single cycle. Recheck hdr_valid[best_idx].
  - If still valid: register hdr_bundle[best_idx] into rdout_hdr and best_idx into rdout_chan. Assert hdr_rdreq[best_idx] for exactly one clock and set rdout_req=1. Go to WAIT_ACK.
  - If no longer valid: go to IDLE with no pop and no request.
- Latency: hdr_rdreq and the rdout_req rise occur on the same edge, N_CHAN+2 clocks after the IDLE cycle that saw the request condition.
- WAIT_ACK: rdout_req, rdout_hdr and rdout_chan are held stable. On rdout_ack, drop rdout_req next edge and go to WAIT_DONE.
  - If rdout_done arrives together with rdout_ack, go directly to IDLE.
- WAIT_DONE: on rdout_done, go to IDLE.
  - rdout_hdr and rdout_chan hold their values until the next GRANT.
- Only one hdr_rdreq bit is ever high, and only in the GRANT cycle.
- en deassert:
  - Checked only in IDLE.
  - An in-flight scan or transaction completes normally.
  - A SCAN that started with en high still grants.
- hdr_valid changes during SCAN: use the value sampled at each channel's compare cycle. Validity is rechecked only at GRANT.
- rdout_done outside WAIT_ACK and WAIT_DONE is ignored.
- Reset mid-transaction: immediate return to IDLE with outputs 0. The popped header is lost; upstream tolerates this.

Optional Feature:
- Macro WVB_ARB_WATCHDOG_EN.
- When defined: a 16-bit counter clears on entry to WAIT_ACK and counts each clock in WAIT_ACK or WAIT_DONE. When it reaches TIMEOUT_CYC:
  - rdout_req drops.
  - rdout_err pulses for 1 clock.
  - State goes to IDLE.
- When undefined: no counter, rdout_err is constant 0, and the arbiter waits indefinitely.

Test Plan:
- N_CHAN=4; ch1 ltc=0x100, ch3 ltc=0x080 valid; rdout_ack on 2nd cycle of req, then rdout_done -> hdr_rdreq=4'b1000 once at N_CHAN+2; rdout_chan=3; rdout_hdr = ch3 bundle; then a rescan selects ch1.
- Tie: ch0 and ch2 both ltc=0x55 -> ch0 granted first, ch2 on the next transaction.
- hdr_valid[2] (the sole candidate) dropped during the last SCAN cycle before GRANT -> no hdr_rdreq, no rdout_req, return to IDLE.
- en=0 with all channels valid -> busy stays 0, no strobes. Drop en during WAIT_DONE -> transaction completes, then IDLE holds.
- rdout_ack and rdout_done in the same cycle -> IDLE next edge. rst_n low during WAIT_ACK -> rdout_req=0 and busy=0 asynchronously.
- With WVB_ARB_WATCHDOG_EN and TIMEOUT_CYC=10, never send rdout_done -> rdout_err pulses exactly once, 10 clocks after WAIT_ACK entry; FSM returns to IDLE.
